// File: rtl/picoctrl_seq.sv
// picoctrl_seq: run-time programmable micro-sequencer; clk/reset_n, run start/release, cond_in (synchronised), prog_we/addr/data RAM load port (IDLE/HALT only), reg_out/reg_wr output registers, pc/busy/halted/err status
module picoctrl_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int NUM_REG = 4,
  parameter int NUM_COND = 4,
  parameter int CALL_DEPTH = 2,
  localparam int RS_W = $clog2(NUM_REG),
  localparam int CS_W = $clog2(NUM_COND),
  localparam int INSTR_W = DATA_W + RS_W + CS_W + 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        run,
  input  logic [NUM_COND-1:0]         cond_in,
  input  logic                        prog_we,
  input  logic [ADDR_W-1:0]           prog_addr,
  input  logic [INSTR_W-1:0]          prog_data,
  output logic [NUM_REG*DATA_W-1:0]   reg_out,
  output logic [NUM_REG-1:0]          reg_wr,
  output logic [ADDR_W-1:0]           pc,
  output logic                        busy,
  output logic                        halted,
  output logic                        err
);
  localparam int SP_W = $clog2(CALL_DEPTH + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DELAY, S_HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [2**SP_W];
  logic [ADDR_W-1:0] stack_d [2**SP_W];
  logic [DATA_W-1:0] dcnt_q, dcnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REG];
  logic [DATA_W-1:0] regs_d [NUM_REG];
  logic [NUM_REG-1:0] reg_wr_q, reg_wr_d;
  logic err_q, err_d;
  logic [NUM_COND-1:0] sync1_q, sync2_q;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0] imm;
  logic [RS_W-1:0] rsel;
  logic [2:0] op;
  logic pol, cen, exec_ok;
  logic [CS_W-1:0] cidx;
  assign imm = instr_q[DATA_W-1:0];
  assign rsel = instr_q[DATA_W +: RS_W];
  assign op = instr_q[DATA_W+RS_W +: 3];
  assign pol = instr_q[DATA_W+RS_W+3];
  assign cidx = instr_q[DATA_W+RS_W+4 +: CS_W];
  assign cen = instr_q[INSTR_W-1];
  assign exec_ok = !cen || (sync2_q[cidx] == pol);
  assign pc_inc = pc_q + 1'b1;
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE || state_q == S_HALT)) mem[prog_addr] <= prog_data;
    instr_q <= mem[pc_q];
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    sp_d = sp_q;
    stack_d = stack_q;
    dcnt_d = dcnt_q;
    regs_d = regs_q;
    reg_wr_d = '0;
    err_d = err_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d = pc_inc;
        if (exec_ok) begin
          case (op)
            3'b001: begin
              regs_d[rsel] = imm;
              reg_wr_d[rsel] = 1'b1;
            end
            3'b010: pc_d = imm[ADDR_W-1:0];
            3'b011: if (imm != '0) begin
              state_d = S_DELAY;
              pc_d = pc_q;
              dcnt_d = imm - 1'b1;
            end
            3'b100: if (sp_q == SP_W'(CALL_DEPTH)) begin
              err_d = 1'b1;
              state_d = S_HALT;
              pc_d = pc_q;
            end else begin
              stack_d[sp_q] = pc_inc;
              sp_d = sp_q + 1'b1;
              pc_d = imm[ADDR_W-1:0];
            end
            3'b101: if (sp_q == '0) begin
              err_d = 1'b1;
              state_d = S_HALT;
              pc_d = pc_q;
            end else begin
              sp_d = sp_q - 1'b1;
              pc_d = stack_q[sp_q - 1'b1];
            end
            3'b110: begin
              state_d = S_HALT;
              pc_d = pc_q;
            end
            default: ;
          endcase
        end
      end
      S_DELAY: begin
        state_d = (dcnt_q == '0) ? S_FETCH : S_DELAY;
        pc_d = (dcnt_q == '0) ? pc_inc : pc_q;
        dcnt_d = (dcnt_q == '0) ? dcnt_q : dcnt_q - 1'b1;
      end
      S_HALT: if (!run) begin
        state_d = S_IDLE;
        pc_d = '0;
        sp_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      sp_q <= '0;
      stack_q <= '{default: '0};
      dcnt_q <= '0;
      regs_q <= '{default: '0};
      reg_wr_q <= '0;
      err_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
      stack_q <= stack_d;
      dcnt_q <= dcnt_d;
      regs_q <= regs_d;
      reg_wr_q <= reg_wr_d;
      err_q <= err_d;
      sync1_q <= cond_in;
      sync2_q <= sync1_q;
    end
  end
  for (genvar k = 0; k < NUM_REG; k++) begin : g_out
    assign reg_out[k*DATA_W +: DATA_W] = regs_q[k];
  end
  assign reg_wr = reg_wr_q;
  assign pc = pc_q;
  assign err = err_q;
  assign busy = state_q == S_FETCH || state_q == S_EXEC || state_q == S_DELAY;
  assign halted = state_q == S_HALT;
endmodule

// File: tb/tb_picoctrl_seq.sv
// tb_picoctrl_seq: random and directed programs checked against an instruction-level timing model
module tb_picoctrl_seq;
  localparam int B = 300;
  localparam logic [2:0] NOP = 3'd0, WR = 3'd1, JMP = 3'd2, DLY = 3'd3, CAL = 3'd4, RET = 3'd5, HLT = 3'd6;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic [3:0] cond_in = '0;
  logic prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [16:0] prog_data = '0;
  logic [31:0] reg_out;
  logic [3:0] reg_wr;
  logic [4:0] pc;
  logic busy, halted, err;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt;
  logic [16:0] prog [32];
  logic [4:0] e_pc [B+1];
  logic [3:0] e_wr [B+1];
  logic e_halt [B+1];
  logic e_err [B+1];
  logic [31:0] e_regs [B+1];
  picoctrl_seq dut (
    .clk(clk), .reset_n(reset_n), .run(run), .cond_in(cond_in),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_out(reg_out), .reg_wr(reg_wr), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] ins(input logic en, input logic [1:0] ci, input logic pol,
                                      input logic [2:0] op, input logic [1:0] r, input logic [7:0] imm);
    return {en, ci, pol, op, r, imm};
  endfunction
  function automatic logic [16:0] u(input logic [2:0] op, input logic [1:0] r, input logic [7:0] imm);
    return ins(1'b0, 2'd0, 1'b0, op, r, imm);
  endfunction
  task automatic clear_prog();
    for (int a = 0; a < 32; a++) prog[a] = u(NOP, 2'd0, 8'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    run = 1'b0;
    prog_we = 1'b0;
    cond_in = '0;
    #1;
    chk("reset outputs", {reg_out, reg_wr, pc, busy, halted, err}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic load_prog();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = 5'(a);
      prog_data = prog[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask
  // Each instruction occupies 2 cycles (+n for an executed DELAY n>0); pc shows the
  // instruction in progress; effects appear on the edge ending its EXEC (start + 2).
  task automatic model(input logic [3:0] cnd);
    logic [7:0] r [4];
    int stk[$];
    int p, t, dur, npc, rs;
    logic [16:0] w;
    logic [7:0] imm;
    bit hlt, er, wr;
    r = '{default: '0};
    p = 0;
    t = 1;
    for (int c = 0; c <= B; c++) e_wr[c] = '0;
    while (t <= B) begin
      w = prog[p];
      imm = w[7:0];
      rs = int'(w[9:8]);
      dur = 2;
      npc = (p + 1) % 32;
      hlt = 0;
      er = 0;
      wr = 0;
      if (!w[16] || cnd[w[15:14]] == w[13]) begin
        case (w[12:10])
          WR: wr = 1;
          JMP: npc = imm % 32;
          DLY: dur = 2 + imm;
          CAL: if (stk.size() == 2) begin hlt = 1; er = 1; end
               else begin stk.push_back(npc); npc = imm % 32; end
          RET: if (stk.size() == 0) begin hlt = 1; er = 1; end
               else npc = stk.pop_back();
          HLT: hlt = 1;
          default: ;
        endcase
      end
      if (hlt) dur = B + 1 - t;
      for (int c = t; c < t + dur && c <= B; c++) begin
        e_pc[c] = 5'(p);
        e_regs[c] = {r[3], r[2], r[1], r[0]};
        e_halt[c] = hlt && c >= t + 2;
        e_err[c] = er && c >= t + 2;
      end
      if (wr) begin
        if (t + 2 <= B) e_wr[t+2][rs] = 1'b1;
        r[rs] = imm;
      end
      if (hlt) break;
      p = npc;
      t += dur;
    end
  endtask
  task automatic run_model(input logic [3:0] cnd, input string tag);
    do_reset();
    load_prog();
    cond_in = cnd;
    model(cnd);
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c <= B; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s pc c%0d", tag, c), pc, e_pc[c]);
      chk($sformatf("%s reg_wr c%0d", tag, c), reg_wr, e_wr[c]);
      chk($sformatf("%s reg_out c%0d", tag, c), reg_out, e_regs[c]);
      chk($sformatf("%s st c%0d", tag, c), {busy, halted, err}, {!e_halt[c], e_halt[c], e_err[c]});
      // junk writes: ignored while busy, harmless once halted
      prog_we = ($urandom_range(0, 3) == 0);
      prog_addr = 5'($urandom);
      prog_data = 17'($urandom);
    end
    @(negedge clk);
    prog_we = 1'b0;
    run = 1'b0;
  endtask
  initial begin
    clear_prog();
    prog[0] = u(WR, 2'd0, 8'hAA);
    prog[1] = u(DLY, 2'd0, 8'd5);
    prog[2] = u(WR, 2'd0, 8'h55);
    prog[3] = u(HLT, 2'd0, 8'd0);
    run_model(4'h0, "delay5");
    prog[1] = u(DLY, 2'd0, 8'd0);
    run_model(4'h0, "delay0");
    clear_prog();
    prog[0] = u(CAL, 2'd0, 8'd4);
    prog[4] = u(CAL, 2'd0, 8'd8);
    prog[8] = u(CAL, 2'd0, 8'd12);
    prog[12] = u(WR, 2'd0, 8'hEE);
    prog[13] = u(HLT, 2'd0, 8'd0);
    run_model(4'h0, "overflow");
    clear_prog();
    prog[0] = u(RET, 2'd0, 8'd0);
    run_model(4'h0, "underflow");
    clear_prog();
    prog[0] = u(JMP, 2'd0, 8'hFE);
    prog[30] = u(WR, 2'd2, 8'h7F);
    run_model(4'h0, "wrap");
    for (int n = 0; n < 25; n++) begin
      for (int a = 0; a < 32; a++) begin
        logic [2:0] op;
        op = 3'($urandom);
        prog[a] = ins($urandom_range(0, 2) == 0, 2'($urandom), 1'($urandom), op, 2'($urandom),
                      op == DLY ? 8'($urandom_range(0, 12)) : 8'($urandom));
      end
      run_model(4'($urandom), $sformatf("rnd%0d", n));
    end
    clear_prog();
    prog[0] = u(WR, 2'd1, 8'h01);
    prog[1] = ins(1'b1, 2'd1, 1'b1, JMP, 2'd0, 8'd1);
    prog[2] = u(WR, 2'd1, 8'h02);
    prog[3] = u(HLT, 2'd0, 8'd0);
    do_reset();
    load_prog();
    cond_in = 4'b0010;
    repeat (3) @(negedge clk);
    run = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      cnt += int'(reg_wr[1]);
    end
    chk("cond hold r1", reg_out[15:8], 8'h01);
    chk("cond hold pc", pc, 5'd1);
    chk("cond hold pulses", cnt, 1);
    @(negedge clk);
    cond_in = 4'b0000;
    for (int i = 0; i < 15 && !halted; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(reg_wr[1]);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      cnt += int'(reg_wr[1]);
    end
    chk("cond drop halted", halted, 1'b1);
    chk("cond drop r1", reg_out[15:8], 8'h02);
    chk("cond drop pulses", cnt, 2);
    chk("cond drop pc", pc, 5'd3);
    clear_prog();
    prog[0] = u(WR, 2'd3, 8'h33);
    prog[1] = u(DLY, 2'd0, 8'd200);
    prog[2] = u(WR, 2'd3, 8'h44);
    prog[3] = u(HLT, 2'd0, 8'd0);
    do_reset();
    load_prog();
    @(negedge clk);
    run = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("pre-reset r3", reg_out[31:24], 8'h33);
    chk("pre-reset busy", {busy, pc}, {1'b1, 5'd1});
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid-delay reset outputs", {reg_out, reg_wr, pc, busy, halted, err}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400 && !halted; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(reg_wr[3]);
    end
    chk("rerun halted", halted, 1'b1);
    chk("rerun r3", reg_out[31:24], 8'h44);
    chk("rerun pc", pc, 5'd3);
    chk("rerun pulses", cnt, 2);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 5'd2;
    prog_data = u(WR, 2'd3, 8'h99);
    @(negedge clk);
    prog_we = 1'b0;
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 400 && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    chk("halt write halted", halted, 1'b1);
    chk("halt write r3", reg_out[31:24], 8'h99);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/picoctrl_seq.md
# picoctrl_seq

Parametrised successor to the fixed 32-word PicoCtrl program ROM and its controller: a self-contained micro-sequencer with a writable program RAM, a configurable number of condition inputs and output registers, conditional execution, and DELAY, CALL/RET and HALT operations. It sits between slow external condition sources (switches, status lines) and the output registers that drive LEDs and peripherals. It replaces hard-coded ROM sequences with programs loaded at run time.

## Interface
- ADDR_W, 5: program address width; DEPTH = 2^ADDR_W words.
- DATA_W, 8: register and immediate width; must be ≥ ADDR_W.
- NUM_REG, 4: output registers; RS_W = clog2(NUM_REG).
- NUM_COND, 4: condition inputs; CS_W = clog2(NUM_COND).
- CALL_DEPTH, 2: return-address stack entries.
- INSTR_W, derived = DATA_W+RS_W+CS_W+5 (17 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level: start from IDLE; release from HALT.
- cond_in  in  NUM_COND  asynchronous condition inputs.
- prog_we  in  1  program RAM write enable.
- prog_addr  in  ADDR_W  program RAM write address.
- prog_data  in  INSTR_W  instruction to write.
- reg_out  out  NUM_REG*DATA_W  output registers; reg k at [k*DATA_W +: DATA_W].
- reg_wr  out  NUM_REG  one-cycle pulse when reg k is written.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH/EXEC/DELAY.
- halted  out  1  high in HALT.
- err  out  1  sticky stack overflow/underflow flag.

## Operation
- Instruction fields, MSB to LSB: cond_en(1), cond_idx(CS_W), cond_pol(1), op(3), reg_sel(RS_W), imm(DATA_W). Default bit positions: en[16], idx[15:14], pol[13], op[12:10], reg[9:8], imm[7:0].
- An instruction executes when cond_en=0 or sync_cond[cond_idx]==cond_pol. Otherwise it is skipped: PC+1, no side effects.
- Ops:
  - 000 NOP.
  - 001 WRITE: reg[reg_sel]=imm, pulse reg_wr.
  - 010 JUMP: PC=imm[ADDR_W-1:0].
  - 011 DELAY: wait imm cycles, then PC+1.
  - 100 CALL: push PC+1, jump to imm.
  - 101 RET: pop into PC.
  - 110 HALT.
  - 111 reserved, executes as NOP.
- States: IDLE, FETCH, EXEC, DELAY, HALT.
  - IDLE: PC=0. run=1 → FETCH.
  - FETCH: synchronous RAM read of PC.
  - EXEC: decode and act; → FETCH, DELAY (imm>0), or HALT.
  - DELAY: count imm-1 down to 0, then PC+1 → FETCH.
  - HALT: run=0 → IDLE, clearing PC and the stack pointer; err and registers are kept.
- PC+1 wraps from DEPTH-1 to 0. Jump/call targets ignore imm bits above ADDR_W.
- DELAY with imm=0 behaves as NOP.
- CALL with a full stack: no push, err=1 → HALT, PC holds the CALL address.
- RET with an empty stack: err=1 → HALT, PC holds the RET address.
- err clears only on reset.
- prog_we is honoured only in IDLE or HALT and ignored otherwise. The RAM is not reset and its contents survive reset_n.
- cond_in passes through a 2-flop synchroniser (sync_cond); EXEC sees the value from 2 edges earlier.

## Timing
- Reset values: reg_out=0, reg_wr=0, pc=0, busy=0, halted=0, err=0, state=IDLE, stack pointer=0, delay counter=0, synchroniser flops=0.
- Each instruction takes 2 cycles (FETCH + EXEC). DELAY n adds exactly n cycles.
- The IDLE→FETCH transition happens on the first edge with run=1. The first EXEC is 2 edges later.
- A WRITE's reg_out and reg_wr pulse become visible in the cycle after EXEC. reg_wr is high for exactly 1 cycle.
- halted rises in the cycle after the HALT EXEC. busy is low in the same cycle.
- Reset asserted mid-operation (any state) forces all outputs to reset values immediately; no completion is attempted.

## Test plan
- Load: 0 WRITE r1=0x01; 1 if c1==1 JUMP 1; 2 WRITE r1=0x02; 3 HALT. Hold cond_in[1]=1, run=1.
  -> r1=0x01, pc alternates at 1.
  -> Drop cond_in[1]: r1=0x02 within 5 cycles, then halted=1, reg_wr[1] pulsed exactly twice.
- Load: 0 WRITE r0=0xAA; 1 DELAY 5; 2 WRITE r0=0x55; 3 HALT.
  -> reg_wr[0] pulses exactly 9 cycles apart, r0 ends at 0x55.
  -> Repeat with DELAY 0: pulses 4 cycles apart.
- CALL_DEPTH=2, three nested CALLs at addresses 0, 4, 8.
  -> err=1, halted=1, pc=8, no write executed at the third target.
  -> Separately, RET as first instruction -> err=1, pc=0.
- Load: 0 JUMP 30; 30 NOP; 31 NOP; 0 overwritten after load to WRITE r2=0x7F then HALT.
  -> pc sequence 0,30,31,0, r2=0x7F (wrap-around).
- Reset mid-DELAY: start DELAY 200, assert reset_n low for 1 cycle at cycle 50.
  -> All outputs zero immediately; after release with run=1 the program reruns from address 0 unchanged.
- prog_we pulses during FETCH/EXEC/DELAY writing 0xFFFF patterns.
  -> RAM unchanged (readback by rerun).
  -> Writes in HALT take effect after run cycles 0→1.
